// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB response multiplexer and its default slave.
// HTRANS transfer types, HRESP codes, data-phase select encoding and the
// default-slave state encoding live here so every file agrees on them.
package ahb_pkg;

  // Master transfer type on HTRANS.
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Slave response codes on HRESP.
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Which slave owns the current data phase.
  typedef enum logic [1:0] {
    DSEL_NONE = 2'b00,
    DSEL_S0   = 2'b01,
    DSEL_S1   = 2'b10,
    DSEL_DEF  = 2'b11
  } dsel_t;

  // Default-slave response sequence: two-cycle ERROR response.
  typedef enum logic [1:0] {
    DEF_IDLE = 2'b00,
    DEF_ERR1 = 2'b01,
    DEF_ERR2 = 2'b10
  } def_state_t;

  // NONSEQ and SEQ are the only transfer types that need a real response;
  // both have HTRANS[1] set.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// AHB default slave for unmapped address space.
// An active transfer (NONSEQ/SEQ) gets the standard two-cycle ERROR
// response: first cycle HREADYOUT=0/HRESP=ERROR, second cycle
// HREADYOUT=1/HRESP=ERROR. IDLE/BUSY transfers get a zero-wait OKAY.
// Outputs are a pure function of state, so feeding HREADY back from the
// response mux cannot form a combinational loop.
// Only instantiated by ahb_resp_mux when AHB_DEFAULT_SLAVE_EN is defined.
module ahb_default_slave (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);
  import ahb_pkg::*;

  // Current and next FSM state; state is visible hierarchically for checkers.
  def_state_t state;
  def_state_t state_next;

  // An address phase addressed to us is accepted this edge.
  logic start;
  assign start = HREADY & HSEL & is_active(HTRANS);

  // State register; reset abandons any response in flight.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= DEF_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_next = state;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state)
      DEF_IDLE: begin
        if (start) state_next = DEF_ERR1;
      end
      DEF_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = DEF_ERR2;
      end
      DEF_ERR2: begin
        HRESP      = HRESP_ERROR;
        state_next = start ? DEF_ERR1 : DEF_IDLE;
      end
      default: begin
        state_next = DEF_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response multiplexer.
// The address-phase select is captured into a data-phase select register
// (dsel) whenever HREADY is high; dsel then steers the owning slave's
// HRDATA/HREADYOUT/HRESP straight to the master with no added latency.
// While a slave inserts wait states HREADY stays low, dsel holds, and a
// following address phase cannot steal the pending data phase.
// Optional feature macro: AHB_DEFAULT_SLAVE_EN adds the HSELDEF input and
// an ahb_default_slave that answers unmapped accesses with ERROR.
//
// Handshake: a transfer's address phase is accepted on a rising HCLK edge
// where HREADY=1; its data phase ends on the first later edge with HREADY=1.
module ahb_resp_mux #(
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL0,
  input  logic          HSEL1,
`ifdef AHB_DEFAULT_SLAVE_EN
  input  logic          HSELDEF,
`endif
  input  logic [1:0]    HTRANS,
  input  logic [DW-1:0] HRDATA_S0,
  input  logic [DW-1:0] HRDATA_S1,
  input  logic          HREADYOUT_S0,
  input  logic          HREADYOUT_S1,
  input  logic          HRESP_S0,
  input  logic          HRESP_S1,
  output logic [DW-1:0] HRDATA,
  output logic          HREADY,
  output logic          HRESP
);
  import ahb_pkg::*;

  // Data-phase owner and the owner the current address phase asks for.
  dsel_t dsel;
  dsel_t dsel_next;

  // Muxed ready, also returned to every slave as its HREADY.
  logic ready_mux;

`ifdef AHB_DEFAULT_SLAVE_EN
  // The default slave only sees a select when no mapped slave is chosen.
  logic def_sel;
  logic def_readyout;
  logic def_resp;

  assign def_sel = HSELDEF & ~HSEL0 & ~HSEL1;

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (def_sel),
    .HTRANS    (HTRANS),
    .HREADY    (ready_mux),
    .HREADYOUT (def_readyout),
    .HRESP     (def_resp)
  );
`else
  // Without a default slave HTRANS has no consumer in this block.
  logic unused_htrans;
  assign unused_htrans = ^HTRANS;
`endif

  // Priority decode of the address-phase selects: S0, then S1, then default.
  always_comb begin
    dsel_next = DSEL_NONE;
    if (HSEL0) begin
      dsel_next = DSEL_S0;
    end else if (HSEL1) begin
      dsel_next = DSEL_S1;
`ifdef AHB_DEFAULT_SLAVE_EN
    end else if (HSELDEF) begin
      dsel_next = DSEL_DEF;
`endif
    end
  end

  // Data-phase select register: load on accepted address phase, hold on wait.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel <= DSEL_NONE;
    end else if (ready_mux) begin
      dsel <= dsel_next;
    end
  end

  // Combinational response steering; slave data passes through unmodified.
  always_comb begin
    HRDATA    = '0;
    ready_mux = 1'b1;
    HRESP     = HRESP_OKAY;
    case (dsel)
      DSEL_S0: begin
        HRDATA    = HRDATA_S0;
        ready_mux = HREADYOUT_S0;
        HRESP     = HRESP_S0;
      end
      DSEL_S1: begin
        HRDATA    = HRDATA_S1;
        ready_mux = HREADYOUT_S1;
        HRESP     = HRESP_S1;
      end
`ifdef AHB_DEFAULT_SLAVE_EN
      DSEL_DEF: begin
        HRDATA    = '0;
        ready_mux = def_readyout;
        HRESP     = def_resp;
      end
`endif
      default: begin
        HRDATA    = '0;
        ready_mux = 1'b1;
        HRESP     = HRESP_OKAY;
      end
    endcase
  end

  assign HREADY = ready_mux;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios followed by a
// randomized run against a transfer-level reference model. The default
// slave scenarios are built only when AHB_DEFAULT_SLAVE_EN is defined.
module tb_ahb_resp_mux;

  localparam int DW = 32;

  // Clock/reset and DUT signals.
  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL0;
  logic          HSEL1;
  logic          sel_def;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HRDATA_S0;
  logic [DW-1:0] HRDATA_S1;
  logic          HREADYOUT_S0;
  logic          HREADYOUT_S1;
  logic          HRESP_S0;
  logic          HRESP_S1;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

`ifdef AHB_DEFAULT_SLAVE_EN
  localparam bit DEF_EN = 1'b1;
  logic HSELDEF;
  assign HSELDEF = sel_def;
`else
  localparam bit DEF_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the data phase (0 none, 1 S0, 2 S1, 3 default)
  // and how many ERROR cycles the default slave still owes.
  int m_owner;
  int m_err;

  always #5 HCLK = ~HCLK;

  ahb_resp_mux #(.DW(DW)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSEL0        (HSEL0),
    .HSEL1        (HSEL1),
`ifdef AHB_DEFAULT_SLAVE_EN
    .HSELDEF      (HSELDEF),
`endif
    .HTRANS       (HTRANS),
    .HRDATA_S0    (HRDATA_S0),
    .HRDATA_S1    (HRDATA_S1),
    .HREADYOUT_S0 (HREADYOUT_S0),
    .HREADYOUT_S1 (HREADYOUT_S1),
    .HRESP_S0     (HRESP_S0),
    .HRESP_S1     (HRESP_S1),
    .HRDATA       (HRDATA),
    .HREADY       (HREADY),
    .HRESP        (HRESP)
  );

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HSEL0        = 1'b0;
    HSEL1        = 1'b0;
    sel_def      = 1'b0;
    HTRANS       = 2'b00;
    HRDATA_S0    = '0;
    HRDATA_S1    = '0;
    HREADYOUT_S0 = 1'b1;
    HREADYOUT_S1 = 1'b1;
    HRESP_S0     = 1'b0;
    HRESP_S1     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESET       = 1'b1;
    HSEL0        = 1'b1;
    HTRANS       = 2'b10;
    HRDATA_S0    = 32'hDEADBEEF;
    HREADYOUT_S0 = 1'b0;
    HRESP_S0     = 1'b1;
    tick();
    tick();
    #2;
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=00000000", HRDATA); end
    checks++; if (HREADY !== 1'b1) begin failures++; $display("FAIL reset_hready got=%b exp=1", HREADY); end
    checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", HRESP); end
    tick();
    HRESET = 1'b0;
    HSEL0  = 1'b0;
    HTRANS = 2'b00;
    #2;
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL release_hrdata got=%h exp=00000000", HRDATA); end
    checks++; if (HREADY !== 1'b1) begin failures++; $display("FAIL release_hready got=%b exp=1", HREADY); end
    tick();
    #2;
    checks++; if (HRESP !== 1'b0 || HREADY !== 1'b1) begin failures++; $display("FAIL release_idle got=%b/%b exp=1/0", HREADY, HRESP); end
    idle_inputs();
  endtask

  // Single S0 read: data must appear exactly one cycle after the address phase.
  task automatic test_s0_read();
    idle_inputs();
    HSEL0     = 1'b1;
    HTRANS    = 2'b10;
    HRDATA_S0 = 32'h12345678;
    #2;
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL s0_addr_phase_hrdata got=%h exp=00000000", HRDATA); end
    tick();
    HSEL0     = 1'b0;
    HTRANS    = 2'b00;
    HRDATA_S0 = 32'hCAFE0001;
    #2;
    checks++; if (HRDATA !== 32'hCAFE0001) begin failures++; $display("FAIL s0_read_hrdata got=%h exp=cafe0001", HRDATA); end
    checks++; if (HREADY !== 1'b1) begin failures++; $display("FAIL s0_read_hready got=%b exp=1", HREADY); end
    checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL s0_read_hresp got=%b exp=0", HRESP); end
    tick();
    idle_inputs();
  endtask

  // S1 inserts two wait states while S0 is addressed next; S1 must keep the bus.
  task automatic test_s1_wait();
    idle_inputs();
    HSEL1  = 1'b1;
    HTRANS = 2'b10;
    tick();
    HSEL1        = 1'b0;
    HSEL0        = 1'b1;
    HREADYOUT_S1 = 1'b0;
    HRDATA_S1    = 32'h11111111;
    HRDATA_S0    = 32'h5555AAAA;
    #2;
    checks++; if (HREADY !== 1'b0 || HRDATA !== 32'h11111111) begin failures++; $display("FAIL s1_wait1 got=%b/%h exp=0/11111111", HREADY, HRDATA); end
    tick();
    HRDATA_S1 = 32'h22222222;
    #2;
    checks++; if (HREADY !== 1'b0 || HRDATA !== 32'h22222222) begin failures++; $display("FAIL s1_wait2 got=%b/%h exp=0/22222222", HREADY, HRDATA); end
    tick();
    HREADYOUT_S1 = 1'b1;
    HRDATA_S1    = 32'h33333333;
    #2;
    checks++; if (HREADY !== 1'b1 || HRDATA !== 32'h33333333) begin failures++; $display("FAIL s1_final got=%b/%h exp=1/33333333", HREADY, HRDATA); end
    tick();
    HSEL0        = 1'b0;
    HTRANS       = 2'b00;
    HRDATA_S0    = 32'h44444444;
    HREADYOUT_S1 = 1'b0;
    #2;
    checks++; if (HREADY !== 1'b1 || HRDATA !== 32'h44444444) begin failures++; $display("FAIL s0_after_s1 got=%b/%h exp=1/44444444", HREADY, HRDATA); end
    tick();
    idle_inputs();
  endtask

  // Both selects at once: slave 0 wins.
  task automatic test_both_sel();
    idle_inputs();
    HSEL0  = 1'b1;
    HSEL1  = 1'b1;
    HTRANS = 2'b10;
    tick();
    HSEL0        = 1'b0;
    HSEL1        = 1'b0;
    HTRANS       = 2'b00;
    HRDATA_S0    = 32'hA0A0A0A0;
    HRDATA_S1    = 32'hB1B1B1B1;
    HREADYOUT_S1 = 1'b0;
    HRESP_S1     = 1'b1;
    #2;
    checks++; if (HRDATA !== 32'hA0A0A0A0) begin failures++; $display("FAIL both_sel_hrdata got=%h exp=a0a0a0a0", HRDATA); end
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL both_sel_ctrl got=%b/%b exp=1/0", HREADY, HRESP); end
    tick();
    idle_inputs();
  endtask

  // Slave ERROR response: data still passes through unchanged.
  task automatic test_error_passthrough();
    idle_inputs();
    HSEL1  = 1'b1;
    HTRANS = 2'b10;
    tick();
    HSEL1        = 1'b0;
    HTRANS       = 2'b00;
    HRDATA_S1    = 32'hDEADC0DE;
    HRESP_S1     = 1'b1;
    HREADYOUT_S1 = 1'b0;
    #2;
    checks++; if (HRDATA !== 32'hDEADC0DE || HRESP !== 1'b1 || HREADY !== 1'b0) begin failures++; $display("FAIL err_cycle1 got=%h/%b/%b exp=deadc0de/0/1", HRDATA, HREADY, HRESP); end
    tick();
    HREADYOUT_S1 = 1'b1;
    #2;
    checks++; if (HRDATA !== 32'hDEADC0DE || HRESP !== 1'b1 || HREADY !== 1'b1) begin failures++; $display("FAIL err_cycle2 got=%h/%b/%b exp=deadc0de/1/1", HRDATA, HREADY, HRESP); end
    tick();
    idle_inputs();
  endtask

`ifdef AHB_DEFAULT_SLAVE_EN
  // Default slave: two-cycle ERROR for active transfers, OKAY for IDLE.
  task automatic test_default();
    idle_inputs();
    sel_def = 1'b1;
    HTRANS  = 2'b10;
    tick();
    sel_def = 1'b0;
    HTRANS  = 2'b00;
    #2;
    checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin failures++; $display("FAIL def_err1 got=%b/%b exp=0/1", HREADY, HRESP); end
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL def_hrdata got=%h exp=00000000", HRDATA); end
    tick();
    #2;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin failures++; $display("FAIL def_err2 got=%b/%b exp=1/1", HREADY, HRESP); end
    tick();
    #2;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL def_okay_after got=%b/%b exp=1/0", HREADY, HRESP); end
    sel_def = 1'b1;
    HTRANS  = 2'b00;
    tick();
    sel_def = 1'b0;
    #2;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL def_idle_okay got=%b/%b exp=1/0", HREADY, HRESP); end
    tick();
    idle_inputs();
  endtask

  // Reset asserted mid-ERR1 clears the response before the next edge.
  task automatic test_reset_mid_error();
    idle_inputs();
    sel_def = 1'b1;
    HTRANS  = 2'b11;
    tick();
    sel_def = 1'b0;
    HTRANS  = 2'b00;
    #2;
    checks++; if (HREADY !== 1'b0) begin failures++; $display("FAIL rst_err_pre got=%b exp=0", HREADY); end
    #1;
    HRESET = 1'b1;
    #1;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL rst_err_async got=%b/%b exp=1/0", HREADY, HRESP); end
    #1;
    HRESET = 1'b0;
    tick();
    #2;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL rst_err_release got=%b/%b exp=1/0", HREADY, HRESP); end
    tick();
    idle_inputs();
  endtask
`endif

  // Randomized traffic with occasional resets against the transfer-level model.
  task automatic test_random();
    logic          do_rst;
    logic [DW-1:0] e_data;
    logic          e_rdy;
    logic          e_resp;
    m_owner = 0;
    m_err   = 0;
    for (int n = 0; n < 500; n++) begin
      do_rst       = ($urandom_range(0, 49) == 0);
      HRESET       = do_rst;
      HSEL0        = ($urandom_range(0, 3) == 0);
      HSEL1        = ($urandom_range(0, 2) == 0);
      sel_def      = DEF_EN && ($urandom_range(0, 2) == 0);
      HTRANS       = 2'($urandom_range(0, 3));
      HRDATA_S0    = $urandom;
      HRDATA_S1    = $urandom;
      HREADYOUT_S0 = ($urandom_range(0, 3) != 0);
      HREADYOUT_S1 = ($urandom_range(0, 3) != 0);
      HRESP_S0     = ($urandom_range(0, 5) == 0);
      HRESP_S1     = ($urandom_range(0, 5) == 0);
      if (do_rst) begin
        m_owner = 0;
        m_err   = 0;
      end
      #2;
      case (m_owner)
        1: begin e_data = HRDATA_S0; e_rdy = HREADYOUT_S0; e_resp = HRESP_S0; end
        2: begin e_data = HRDATA_S1; e_rdy = HREADYOUT_S1; e_resp = HRESP_S1; end
        3: begin e_data = '0; e_rdy = (m_err != 2); e_resp = (m_err != 0); end
        default: begin e_data = '0; e_rdy = 1'b1; e_resp = 1'b0; end
      endcase
      checks++; if (HRDATA !== e_data || HREADY !== e_rdy || HRESP !== e_resp) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h/%b/%b exp=%h/%b/%b", n, HRDATA, HREADY, HRESP, e_data, e_rdy, e_resp);
      end
      @(posedge HCLK);
      if (!do_rst) begin
        if (m_err > 0) m_err--;
        if (e_rdy) begin
          if (HSEL0) m_owner = 1;
          else if (HSEL1) m_owner = 2;
          else if (sel_def) m_owner = 3;
          else m_owner = 0;
          if (m_owner == 3 && HTRANS[1]) m_err = 2;
        end
      end
      #1;
    end
    HRESET = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_s0_read();
    test_s1_wait();
    test_both_sel();
    test_error_passthrough();
`ifdef AHB_DEFAULT_SLAVE_EN
    test_default();
    test_reset_mid_error();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
